// File: rtl/token_multiplier.sv
// token_multiplier: serial token expander.
// Each '1' on `a` is replayed as f = min(factor, MAX_FACTOR) consecutive '1's on `b`.
// The first copy goes out in the same cycle the token arrives. Copies that are still
// owed are held in `pending` and emitted one per cycle, in arrival order.
// If the backlog would exceed MAX_PENDING, the block latches a sticky overflow error.
// While in error, pending is frozen and b stays 0. Only rst clears the error.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   a        in   incoming token stream, one bit per cycle
//   factor   in   multiplication factor for a token on `a` this cycle (clamped)
//   b        out  expanded token stream
//   pending  out  registered count of owed tokens not yet emitted
//   busy     out  pending != 0
//   overflow out  sticky backlog-overflow flag (registered)
module token_multiplier #(
    parameter int unsigned MAX_FACTOR  = 4,
    parameter int unsigned MAX_PENDING = 200,
    localparam int unsigned FW = $clog2(MAX_FACTOR + 1),
    localparam int unsigned PW = $clog2(MAX_PENDING + MAX_FACTOR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    input  logic [FW-1:0] factor,
    output logic          b,
    output logic [PW-1:0] pending,
    output logic          busy,
    output logic          overflow
);

    localparam logic [FW-1:0] MaxF = FW'(MAX_FACTOR);
    localparam logic [PW-1:0] MaxP = PW'(MAX_PENDING);

    typedef enum logic {StRun, StError} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pending_q, pending_d;

    logic [FW-1:0] f;
    logic [PW-1:0] demand;
    logic [PW-1:0] total;
    logic [PW-1:0] next;

    always_comb begin
        f      = (factor > MaxF) ? MaxF : factor;
        demand = a ? PW'(f) : '0;
        // PW is sized so that pending_q + MAX_FACTOR cannot wrap.
        total  = pending_q + demand;
        // The cycle that causes the overflow still emits a copy. Only later cycles are
        // silenced.
        b      = (total != '0) && (state_q == StRun) && !rst;
        next   = total - {{(PW-1){1'b0}}, b};

        state_d   = state_q;
        pending_d = pending_q;
        if (state_q == StRun) begin
            if (next > MaxP) begin
                // Discard the offending demand and keep the old backlog.
                state_d = StError;
            end else begin
                pending_d = next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign pending  = pending_q;
    assign busy     = (pending_q != '0);
    assign overflow = (state_q == StError);

endmodule

// File: tb/tb_token_multiplier.sv
module tb_token_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic [2:0] factor;
    logic       b;
    logic [7:0] pending;
    logic       busy;
    logic       overflow;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Scoreboard: the expected b and pending are pushed when a step is driven.
    // They are popped when the DUT output is sampled.
    logic qb[$];
    int   qp[$];

    token_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .factor  (factor),
        .b       (b),
        .pending (pending),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a posedge. It drives the inputs and checks b before the
    // next edge. After that edge it checks pending (ep < 0 skips the pending check).
    task automatic step(input string tag, input logic ai, input logic [2:0] fi,
                        input logic eb, input int ep);
        logic eb_q;
        int   ep_q;
        a      = ai;
        factor = fi;
        qb.push_back(eb);
        qp.push_back(ep);
        #3;
        eb_q = qb.pop_front();
        chk({tag, ".b"}, {31'd0, b}, {31'd0, eb_q});
        @(posedge clk);
        #1;
        ep_q = qp.pop_front();
        if (ep_q >= 0) chk({tag, ".pending"}, {24'd0, pending}, ep_q);
    endtask

    // Asserts reset between edges and checks that it takes effect without a clock edge.
    task automatic async_reset(input string tag);
        a      = 1'b1;
        factor = 3'd2;
        #3;
        rst = 1'b1;
        #1;
        chk({tag, ".pending"}, {24'd0, pending}, 0);
        chk({tag, ".overflow"}, {31'd0, overflow}, 0);
        chk({tag, ".busy"}, {31'd0, busy}, 0);
        chk({tag, ".b"}, {31'd0, b}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [25:0] dbl_a;
        logic [25:0] dbl_b;
        logic [7:0]  mix_b;
        int          mix_p[7];
        logic [2:0]  mix_f[3];

        dbl_a   = 26'b10010011000110100001100100;
        dbl_b   = 26'b11011011110111111001111110;
        mix_b   = 8'b11111110;
        mix_p   = '{2, 1, 4, 3, 2, 1, 0};
        mix_f   = '{3'd3, 3'd0, 3'd4};

        rst    = 1'b1;
        a      = 1'b1;
        factor = 3'd2;
        #2;
        chk("reset.pending", {24'd0, pending}, 0);
        chk("reset.overflow", {31'd0, overflow}, 0);
        chk("reset.busy", {31'd0, busy}, 0);
        chk("reset.b_forced0", {31'd0, b}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Doubling.
        for (int i = 25; i >= 0; i--) step("dbl", dbl_a[i], 3'd2, dbl_b[i], -1);
        chk("dbl.end_pending", {24'd0, pending}, 0);
        chk("dbl.end_busy", {31'd0, busy}, 0);

        // Pass-through, then drop.
        step("pass", 1'b1, 3'd1, 1'b1, 0);
        step("pass", 1'b0, 3'd1, 1'b0, 0);
        step("pass", 1'b1, 3'd1, 1'b1, 0);
        step("pass", 1'b1, 3'd1, 1'b1, 0);
        for (int i = 0; i < 4; i++) step("drop", 1'b1, 3'd0, 1'b0, 0);

        // Mixed factor: 3, 0, 4, then idle.
        for (int i = 0; i < 7; i++)
            step("mix", (i < 3) ? 1'b1 : 1'b0, (i < 3) ? mix_f[i] : 3'd0, mix_b[7-i],
                 mix_p[i]);
        step("mix.idle", 1'b0, 3'd0, mix_b[0], 0);

        // A factor above MAX_FACTOR is clamped to 4.
        step("clamp", 1'b1, 3'd7, 1'b1, 3);
        step("clamp", 1'b0, 3'd0, 1'b1, 2);
        step("clamp", 1'b0, 3'd0, 1'b1, 1);
        step("clamp", 1'b0, 3'd0, 1'b1, 0);
        step("clamp", 1'b0, 3'd0, 1'b0, 0);

        // Overflow boundary: with f=2, each cycle adds one owed token.
        for (int i = 0; i < 200; i++) step("fill", 1'b1, 3'd2, 1'b1, i + 1);
        chk("fill.overflow", {31'd0, overflow}, 0);
        step("edge_f1", 1'b1, 3'd1, 1'b1, 200);
        chk("edge_f1.overflow", {31'd0, overflow}, 0);
        step("ovf", 1'b1, 3'd2, 1'b1, 200);
        chk("ovf.overflow", {31'd0, overflow}, 1);
        chk("ovf.busy", {31'd0, busy}, 1);

        // Sticky error: inputs are ignored.
        for (int i = 0; i < 50; i++)
            step("sticky", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 200);
        chk("sticky.overflow", {31'd0, overflow}, 1);

        async_reset("rst_err");

        // Build a backlog of 37 owed tokens, then reset mid-burst.
        for (int i = 0; i < 37; i++) step("burst", 1'b1, 3'd2, 1'b1, i + 1);
        async_reset("rst_mid");
        step("resume", 1'b1, 3'd2, 1'b1, 1);
        step("resume", 1'b0, 3'd2, 1'b1, 0);
        step("resume", 1'b0, 3'd2, 1'b0, 0);
        chk("resume.overflow", {31'd0, overflow}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
